// File: rtl/inst_boot_loader_pkg.sv
// inst_boot_loader_pkg: shared state encoding and header framing constants for the boot loader
package inst_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
        S_SETTLE,
        S_RUN,
        S_ERR
    } boot_state_t;

    localparam int         HDR_BYTES = 2;
    localparam logic [1:0] HDR_LAST  = 2'(HDR_BYTES - 1);

endpackage

// File: rtl/inst_boot_loader_byte_packer.sv
// inst_boot_loader_byte_packer: assembles little-endian bytes into a 32-bit word
module inst_boot_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_cnt,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    assign o_cnt       = r_cnt;
    assign o_word      = {i_byte, r_word[31:8]};
    assign o_word_done = i_accept && r_cnt == 2'd3;

    // Shift each accepted byte in from the top so byte 0 ends up in bits [7:0]
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clear) begin
            r_cnt  <= 2'd0;
        end else if (i_accept) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= o_word;
        end
    end

endmodule

// File: rtl/inst_boot_loader.sv
// inst_boot_loader: loads a header-framed byte image into instruction memory, then releases core reset
module inst_boot_loader
    import inst_boot_loader_pkg::*;
#(
    parameter int DEPTH_WORDS   = 256,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    input  logic        i_boot_start,
    output logic [31:0] o_inst_addr_load,
    output logic [31:0] o_inst_load,
    output logic        o_load_en,
    output logic        o_rst_n_mem,
    output logic        o_core_rst_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    boot_state_t r_state, w_next;
    logic        r_mem_up;
    logic [15:0] r_count, r_idx, r_settle;
    logic [31:0] r_addr, r_inst;
    logic        r_load_en;
    logic        w_rx_ready, w_accept, w_hdr_done, w_clear, w_word_done;
    logic [1:0]  w_cnt;
    logic [31:0] w_word;
    logic [15:0] w_hdr_count;

    // Bytes are only taken while collecting a header or data, and never before memory leaves reset
    assign w_rx_ready  = r_mem_up && (r_state == S_HDR || r_state == S_DATA);
    assign w_accept    = i_rx_valid && w_rx_ready;
    assign w_hdr_done  = r_state == S_HDR && w_accept && w_cnt == HDR_LAST;
    assign w_hdr_count = w_word[31:16];
    assign w_clear     = w_hdr_done || !(r_state == S_HDR || r_state == S_DATA);

    inst_boot_loader_byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte      (i_rx_data),
        .o_cnt       (w_cnt),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_HDR;
        else          r_state <= w_next;
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next       = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_core_rst_n = 1'b0;
        case (r_state)
            S_HDR: begin
                o_busy = r_mem_up;
                if (w_hdr_done)
                    w_next = (w_hdr_count == 16'd0) ? S_SETTLE :
                             (w_hdr_count > 16'(DEPTH_WORDS)) ? S_ERR : S_DATA;
            end
            S_DATA: begin
                o_busy = 1'b1;
                if (w_word_done) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_busy = 1'b1;
                w_next = (r_idx + 16'd1 == r_count) ? S_SETTLE : S_DATA;
            end
            S_SETTLE: begin
                o_busy = 1'b1;
                if (r_settle == 16'(SETTLE_CYCLES - 1)) w_next = S_RUN;
            end
            S_RUN: begin
                o_done       = 1'b1;
                o_core_rst_n = 1'b1;
                if (i_boot_start) w_next = S_HDR;
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_boot_start) w_next = S_HDR;
            end
            default: w_next = S_HDR;
        endcase
    end

    // Datapath: word counters, settle timer and the registered memory write port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_up  <= 1'b0;
            r_count   <= 16'd0;
            r_idx     <= 16'd0;
            r_settle  <= 16'd0;
            r_addr    <= 32'd0;
            r_inst    <= 32'd0;
            r_load_en <= 1'b0;
        end else begin
            r_mem_up  <= 1'b1;
            r_load_en <= w_next == S_WRITE;
            r_settle  <= (r_state == S_SETTLE) ? r_settle + 16'd1 : 16'd0;
            if (w_hdr_done) r_count <= w_hdr_count;
            if (r_state == S_HDR) r_idx <= 16'd0;
            else if (r_state == S_WRITE) r_idx <= r_idx + 16'd1;
            if (w_next == S_WRITE) begin
                r_addr <= 32'({r_idx, 2'b00});
                r_inst <= w_word;
            end
        end
    end

    assign o_rx_ready       = w_rx_ready;
    assign o_rst_n_mem      = r_mem_up;
    assign o_load_en        = r_load_en;
    assign o_inst_addr_load = r_addr;
    assign o_inst_load      = r_inst;

endmodule

// File: tb/tb_inst_boot_loader.sv
// tb_inst_boot_loader: randomized image loads checked by a write scoreboard and status checks
module tb_inst_boot_loader;

    localparam int DEPTH  = 256;
    localparam int SETTLE = 2;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        boot_start = 1'b0;
    logic        rx_ready, load_en, rst_n_mem, core_rst_n, busy, done, err;
    logic [31:0] addr, inst;

    always #5 clk = ~clk;

    inst_boot_loader #(.DEPTH_WORDS(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rx_valid       (rx_valid),
        .i_rx_data        (rx_data),
        .o_rx_ready       (rx_ready),
        .i_boot_start     (boot_start),
        .o_inst_addr_load (addr),
        .o_inst_load      (inst),
        .o_load_en        (load_en),
        .o_rst_n_mem      (rst_n_mem),
        .o_core_rst_n     (core_rst_n),
        .o_busy           (busy),
        .o_done           (done),
        .o_err            (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] none[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, including its cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && load_en === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", addr, inst);
            end else begin
                e = q.pop_front();
                chk32("write_addr", addr, e.addr);
                chk32("write_data", inst, e.data);
                chk32("write_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int tcyc);
        int n;
        rx_valid = 1'b1;
        rx_data  = b;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (n == BUDGET) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got ready=0 expected ready=1 within %0d cycles", BUDGET);
            rx_valid = 1'b0;
            tcyc = -1;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tcyc = cyc;
    endtask

    task automatic pulse_boot();
        boot_start = 1'b1;
        @(posedge clk);
        #1;
        boot_start = 1'b0;
    endtask

    task automatic wait_run(input int ref_c, input int delta, input string name);
        int n;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (core_rst_n) break;
        end
        if (n == BUDGET) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got core_rst_n=0 expected 1", name);
        end else begin
            chk32({name, "_latency"}, 32'(cyc - ref_c), 32'(delta));
        end
        chk1("run_done", done, 1'b1);
        chk1("run_busy", busy, 1'b0);
        chk1("run_rx_ready", rx_ready, 1'b0);
        chk1("run_err", err, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic reboot();
        pulse_boot();
        chk1("reboot_core_rst_n", core_rst_n, 1'b0);
        chk1("reboot_done", done, 1'b0);
        chk1("reboot_rx_ready", rx_ready, 1'b1);
        chk1("reboot_busy", busy, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_rx_ready"}, rx_ready, 1'b0);
        chk32({tag, "_addr"}, addr, 32'd0);
        chk32({tag, "_inst"}, inst, 32'd0);
        chk1({tag, "_load_en"}, load_en, 1'b0);
        chk1({tag, "_rst_n_mem"}, rst_n_mem, 1'b0);
        chk1({tag, "_core_rst_n"}, core_rst_n, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    // Sends header + image; expected word i is bytes 4i..4i+3 read little-endian at byte address 4i
    task automatic load_image(input int cnt, input logic [7:0] img[$], input bit gaps,
                              input bit drop10, input bit poke, input int stop);
        int          t;
        int          sent;
        logic [15:0] c;
        logic [31:0] w;
        logic [7:0]  b;
        c = 16'(cnt);
        sent = 0;
        send_byte(c[7:0], t);
        send_byte(c[15:8], t);
        for (int wi = 0; wi < cnt; wi++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (stop >= 0 && sent == stop) return;
                b = (img.size() != 0) ? img[wi * 4 + k] : 8'($urandom);
                w = w | (32'(b) << (8 * k));
                if (gaps && $urandom_range(0, 3) == 0) begin
                    if (poke && $urandom_range(0, 1) == 0) pulse_boot();
                    else idle($urandom_range(1, 6));
                end
                if (drop10 && wi == 0 && k == 2) idle(10);
                send_byte(b, t);
                sent++;
            end
            q.push_back('{32'(wi * 4), w, t});
        end
        wait_run(t, SETTLE + 1, "image_settle");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fixed[$];
        int         t;
        fixed = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        #2 rst_n = 1'b0;
        #1 check_reset("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk1("mem_before_edge", rst_n_mem, 1'b0);
        @(posedge clk);
        #1;
        chk1("mem_after_edge", rst_n_mem, 1'b1);
        chk1("hdr_rx_ready", rx_ready, 1'b1);
        chk1("hdr_busy", busy, 1'b1);

        load_image(2, fixed, 1'b0, 1'b0, 1'b0, -1);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        idle(5);
        chk1("run_backpressure", rx_ready, 1'b0);
        rx_valid = 1'b0;

        reboot();
        send_byte(8'h00, t);
        send_byte(8'h00, t);
        wait_run(t, SETTLE, "empty_settle");

        reboot();
        send_byte(8'h01, t);
        send_byte(8'h01, t);
        chk1("err_flag", err, 1'b1);
        chk1("err_core_rst_n", core_rst_n, 1'b0);
        chk1("err_busy", busy, 1'b0);
        chk1("err_rx_ready", rx_ready, 1'b0);
        idle(5);
        chk1("err_hold", err, 1'b1);
        chk1("err_hold_core", core_rst_n, 1'b0);
        pulse_boot();
        chk1("err_cleared", err, 1'b0);
        chk1("err_restart_ready", rx_ready, 1'b1);

        load_image(3, none, 1'b1, 1'b1, 1'b1, -1);
        reboot();
        for (int i = 0; i < 4; i++) begin
            load_image($urandom_range(1, 8), none, 1'b1, 1'b0, i == 0, -1);
            reboot();
        end

        load_image(DEPTH, none, 1'b0, 1'b0, 1'b0, -1);
        reboot();
        load_image(1, none, 1'b1, 1'b0, 1'b0, -1);
        reboot();

        load_image(8, none, 1'b0, 1'b0, 1'b0, 14);
        #2 rst_n = 1'b0;
        #1 check_reset("midload_reset");
        chk32("midload_queue", 32'(q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_image(2, none, 1'b1, 1'b0, 1'b0, -1);

        chk32("final_queue", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
